if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller for the IF stage.
- Owns the fetch PC and sequences the SRAM-like instruction bus (req / addr_ok / data_ok).
- Selects the next PC: exception flush > branch > sequential.
- Holds one fetched instruction in a single-entry output buffer for ID; raises a stall request to the pipeline controller while fetch is bubbling.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- stall_i  in  1  ID cannot accept; output buffer must hold.
- flush_i  in  1  exception/eret redirect pulse.
- new_pc_i  in  32  flush target.
- branch_flag_i  in  1  branch-taken pulse from ID.
- branch_to_addr_i  in  32  branch target.
- inst_req_o  out  1  bus request.
- inst_addr_o  out  32  bus address.
- inst_addr_ok_i  in  1  address accepted.
- inst_data_ok_i  in  1  read data valid.
- inst_rdata_i  in  32  read data.
- valid_o  out  1  output buffer holds an instruction.
- pc_o  out  32  PC of buffered instruction.
- inst_o  out  32  buffered instruction.
- adel_o  out  1  fetch address error (see Optional Feature).
- stall_req_o  out  1  fetch bubble; combinational: valid_o==0 and state is REQ or WAIT.

Behaviour:
- Reset (rst_i==0 at posedge):
  - state=IDLE, pc_r=RESET_PC.
  - inst_req_o=0, inst_addr_o=RESET_PC, valid_o=0, pc_o=0, inst_o=0, adel_o=0.
  - cancel=0, pend_vld=0.
- Reset mid-transaction: same reset values; the bus is reset in the same cycle.
- Buffer consumed in a cycle with valid_o=1 and stall_i=0; valid_o then clears unless reloaded the same edge.
- States:
  - IDLE: -> REQ on the next cycle out of reset.
  - REQ:
    - inst_req_o=1 only when valid_o==0 or the buffer is consumed this cycle; inst_addr_o=pc_r.
    - Once inst_req_o=1, inst_req_o and inst_addr_o are held stable until inst_addr_ok_i.
    - On handshake -> WAIT.
  - WAIT: inst_req_o=0. On inst_data_ok_i:
    - cancel==1: drop data, clear cancel, pc_r=pend_pc, pend_vld=0, -> REQ.
    - else: load buffer next edge (valid_o=1, inst_o=inst_rdata_i, pc_o=request address), -> REQ.
    - pc_r = pend_vld ? pend_pc : pc_r+PC_STEP; pend_vld cleared.
- Latency: data_ok at edge N -> valid_o=1 after edge N. Minimum 2 cycles between issued requests.
- One outstanding request maximum. A request issues only when the buffer is free, so data_ok never finds a full buffer.
- flush_i:
  - Clears valid_o next edge.
  - IDLE, or REQ with no handshake started: pc_r=new_pc_i directly.
  - Request outstanding (REQ with req high, or WAIT): cancel=1, pend_pc=new_pc_i, pend_vld=1; the in-flight response is discarded.
  - Same cycle as inst_addr_ok_i: request accepted, cancel=1, -> WAIT.
  - Same cycle as data_ok: data dropped, next request uses new_pc_i.
- branch_flag_i:
  - Never clears the buffer and never cancels.
  - An in-flight fetch is the delay slot and is delivered.
  - Target stored as pend_pc (pend_vld=1) if a request is outstanding; otherwise pc_r=branch_to_addr_i.
- flush_i and branch_flag_i in the same cycle: flush wins, branch ignored.
- A second flush while cancel=1 overwrites pend_pc; only one response is discarded.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - In REQ, if pc_r[1:0]!=0: no bus request.
  - Buffer loads next edge with valid_o=1, pc_o=pc_r, inst_o=0, adel_o=1.
  - State -> IDLE-hold; fetch resumes only on flush_i, which clears adel_o.
- Undefined: adel_o tied 0; misaligned address issued to the bus unchanged.

Test Plan:
- Reset release, bus returns addr_ok same cycle and data_ok 1 cycle later, stall_i=0 -> addrs BFC0_0000, BFC0_0004, BFC0_0008 issued; valid_o pulses with matching pc_o/inst_o; stall_req_o=0 while valid_o=1.
- stall_i=1 for 5 cycles with valid_o=1 (pc_o=BFC0_0004) -> pc_o/inst_o stable, inst_req_o=0; after release, next request BFC0_0008.
- flush_i, new_pc_i=BFC0_0380 while in WAIT for BFC0_0010 -> valid_o=0 next edge, BFC0_0010 data dropped, next inst_addr_o=BFC0_0380.
- branch_flag_i, target=BFC0_0100 while delay slot BFC0_000C in flight -> BFC0_000C delivered to valid_o, next request BFC0_0100.
- flush_i (BFC0_0380) and branch_flag_i (BFC0_0100) same cycle, addr_ok held low 3 cycles -> inst_addr_o stable until accepted; response dropped; next request BFC0_0380.
- With IF_ALIGN_CHECK_EN, branch to BFC0_0102 -> no bus request; valid_o=1, adel_o=1, pc_o=BFC0_0102; flush to BFC0_0380 restarts fetch. Without the macro, BFC0_0102 issued and adel_o=0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch controller.
// Owns the fetch PC and drives the SRAM-like instruction bus (req/addr_ok/data_ok).
// Next-PC priority: flush > branch > sequential.
// A single-entry output buffer feeds ID.
// Optional misaligned-fetch trap is enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_to_addr_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        adel_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] pend_pc;
  logic        pend_vld;
  logic        cancel;
  logic        consume;
  logic        buf_free;
  logic        misalign;

  // ID takes the buffered instruction this cycle
  assign consume  = valid_o & ~stall_i;
  // A new fetch may start only if the buffer is empty or being drained now
  assign buf_free = ~valid_o | consume;

`ifdef IF_ALIGN_CHECK_EN
  logic adel_r;
  assign misalign = (pc_r[1:0] != 2'b00);
  assign adel_o   = adel_r;
`else
  assign misalign = 1'b0;
  assign adel_o   = 1'b0;
`endif

  // The request stays stable until addr_ok: once raised, valid_o is 0 and
  // pc_r is only redirected through pend_pc while a request is outstanding.
  assign inst_req_o  = (state == S_REQ) & buf_free & ~misalign;
  assign inst_addr_o = pc_r;
  assign stall_req_o = ~valid_o & ((state == S_REQ) | (state == S_WAIT));

  // Fetch FSM, PC selection and output buffer
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      pc_r     <= RESET_PC;
      pend_pc  <= '0;
      pend_vld <= 1'b0;
      cancel   <= 1'b0;
      valid_o  <= 1'b0;
      pc_o     <= '0;
      inst_o   <= '0;
`ifdef IF_ALIGN_CHECK_EN
      adel_r   <= 1'b0;
`endif
    end else begin
      if (consume) valid_o <= 1'b0;
      if (flush_i) begin
        valid_o <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        adel_r  <= 1'b0;
`endif
      end

      case (state)
        S_IDLE: begin
          if (flush_i)            pc_r <= new_pc_i;
          else if (branch_flag_i) pc_r <= branch_to_addr_i;
          state <= S_REQ;
        end

        S_REQ: begin
          if (inst_req_o) begin
            // Request on the bus: redirects are deferred to pend_pc
            if (flush_i) begin
              cancel   <= 1'b1;
              pend_pc  <= new_pc_i;
              pend_vld <= 1'b1;
            end else if (branch_flag_i && !cancel) begin
              pend_pc  <= branch_to_addr_i;
              pend_vld <= 1'b1;
            end
            if (inst_addr_ok_i) state <= S_WAIT;
`ifdef IF_ALIGN_CHECK_EN
          end else if (misalign && buf_free && !flush_i) begin
            valid_o <= 1'b1;
            pc_o    <= pc_r;
            inst_o  <= '0;
            adel_r  <= 1'b1;
            state   <= S_HOLD;
`endif
          end else begin
            if (flush_i)            pc_r <= new_pc_i;
            else if (branch_flag_i) pc_r <= branch_to_addr_i;
          end
        end

        S_WAIT: begin
          if (inst_data_ok_i) begin
            if (!cancel && !flush_i) begin
              valid_o <= 1'b1;
              inst_o  <= inst_rdata_i;
              pc_o    <= pc_r;
            end
            cancel   <= 1'b0;
            pend_vld <= 1'b0;
            // Response retires here, so same-cycle redirects go straight to pc_r
            if (flush_i)                       pc_r <= new_pc_i;
            else if (branch_flag_i && !cancel) pc_r <= branch_to_addr_i;
            else if (pend_vld)                 pc_r <= pend_pc;
            else                               pc_r <= pc_r + PC_STEP;
            state <= S_REQ;
          end else if (flush_i) begin
            cancel   <= 1'b1;
            pend_pc  <= new_pc_i;
            pend_vld <= 1'b1;
          end else if (branch_flag_i && !cancel) begin
            pend_pc  <= branch_to_addr_i;
            pend_vld <= 1'b1;
          end
        end

`ifdef IF_ALIGN_CHECK_EN
        S_HOLD: begin
          if (flush_i) begin
            pc_r  <= new_pc_i;
            state <= S_REQ;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed, table-driven bench for if_fetch_ctrl.
module tb_if_fetch_ctrl;

  localparam logic [31:0] B = 32'hBFC0_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, branch_flag_i;
  logic [31:0] new_pc_i, branch_to_addr_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o, inst_o;
  logic        adel_o, stall_req_o;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_ctrl #(.RESET_PC(32'hBFC0_0000), .PC_STEP(32'd4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .new_pc_i(new_pc_i), .branch_flag_i(branch_flag_i),
    .branch_to_addr_i(branch_to_addr_i), .inst_req_o(inst_req_o),
    .inst_addr_o(inst_addr_o), .inst_addr_ok_i(inst_addr_ok_i),
    .inst_data_ok_i(inst_data_ok_i), .inst_rdata_i(inst_rdata_i),
    .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .adel_o(adel_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        st, fl;
    logic [31:0] np;
    logic        br;
    logic [31:0] bt;
    logic        aok, dok;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc, e_inst;
    logic        e_sreq, e_adel;
  } vec_t;

  vec_t tbl[33];

  function automatic vec_t v(input logic st, fl, input logic [31:0] np,
                             input logic br, input logic [31:0] bt,
                             input logic aok, dok, input logic [31:0] rd,
                             input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep, ei,
                             input logic es, ead);
    vec_t r;
    r.st = st; r.fl = fl; r.np = np; r.br = br; r.bt = bt;
    r.aok = aok; r.dok = dok; r.rd = rd;
    r.e_req = er; r.e_addr = ea; r.e_vld = ev; r.e_pc = ep; r.e_inst = ei;
    r.e_sreq = es; r.e_adel = ead;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance one cycle
  task automatic apply(input vec_t t, input string tag);
    stall_i = t.st; flush_i = t.fl; new_pc_i = t.np;
    branch_flag_i = t.br; branch_to_addr_i = t.bt;
    inst_addr_ok_i = t.aok; inst_data_ok_i = t.dok; inst_rdata_i = t.rd;
    #1;
    chk({tag, ".req"}, {31'd0, inst_req_o}, {31'd0, t.e_req});
    if (t.e_req) chk({tag, ".addr"}, inst_addr_o, t.e_addr);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, t.e_vld});
    if (t.e_vld) begin
      chk({tag, ".pc"}, pc_o, t.e_pc);
      chk({tag, ".inst"}, inst_o, t.e_inst);
    end
    chk({tag, ".stall_req"}, {31'd0, stall_req_o}, {31'd0, t.e_sreq});
    chk({tag, ".adel"}, {31'd0, adel_o}, {31'd0, t.e_adel});
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"}, {31'd0, inst_req_o}, 32'd0);
    chk({tag, ".addr"}, inst_addr_o, B);
    chk({tag, ".valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, ".pc"}, pc_o, 32'd0);
    chk({tag, ".inst"}, inst_o, 32'd0);
    chk({tag, ".adel"}, {31'd0, adel_o}, 32'd0);
    chk({tag, ".stall_req"}, {31'd0, stall_req_o}, 32'd0);
  endtask

  initial begin
    // st fl np       br bt       aok dok rd            | req addr      vld pc        inst          sreq adel
    tbl[0]  = v(0,0,0,      0,0,       0,0,0,            0,B,        0,0,      0,            0,0);
    tbl[1]  = v(0,0,0,      0,0,       1,0,0,            1,B,        0,0,      0,            1,0);
    tbl[2]  = v(0,0,0,      0,0,       0,1,32'hA000_0000,0,0,        0,0,      0,            1,0);
    tbl[3]  = v(0,0,0,      0,0,       1,0,0,            1,B+4,      1,B,      32'hA000_0000,0,0);
    tbl[4]  = v(0,0,0,      0,0,       0,1,32'hA000_0004,0,0,        0,0,      0,            1,0);
    for (int i = 5; i < 10; i++)
      tbl[i] = v(1,0,0,     0,0,       0,0,0,            0,0,        1,B+4,    32'hA000_0004,0,0);
    tbl[10] = v(0,0,0,      0,0,       1,0,0,            1,B+8,      1,B+4,    32'hA000_0004,0,0);
    tbl[11] = v(0,0,0,      0,0,       0,1,32'hA000_0008,0,0,        0,0,      0,            1,0);
    tbl[12] = v(0,0,0,      0,0,       1,0,0,            1,B+'hC,    1,B+8,    32'hA000_0008,0,0);
    tbl[13] = v(0,0,0,      1,B+'h100, 0,0,0,            0,0,        0,0,      0,            1,0);
    tbl[14] = v(0,0,0,      0,0,       0,1,32'hA000_000C,0,0,        0,0,      0,            1,0);
    tbl[15] = v(0,0,0,      0,0,       1,0,0,            1,B+'h100,  1,B+'hC,  32'hA000_000C,0,0);
    tbl[16] = v(0,0,0,      0,0,       0,1,32'hB000_0100,0,0,        0,0,      0,            1,0);
    tbl[17] = v(0,0,0,      0,0,       1,0,0,            1,B+'h104,  1,B+'h100,32'hB000_0100,0,0);
    tbl[18] = v(0,1,B+'h380,0,0,       0,0,0,            0,0,        0,0,      0,            1,0);
    tbl[19] = v(0,0,0,      0,0,       0,1,32'hDEAD_DEAD,0,0,        0,0,      0,            1,0);
    tbl[20] = v(0,1,B+'h500,1,B+'h100, 0,0,0,            1,B+'h380,  0,0,      0,            1,0);
    tbl[21] = v(0,1,B+'h540,0,0,       0,0,0,            1,B+'h380,  0,0,      0,            1,0);
    tbl[22] = v(0,0,0,      0,0,       0,0,0,            1,B+'h380,  0,0,      0,            1,0);
    tbl[23] = v(0,0,0,      0,0,       1,0,0,            1,B+'h380,  0,0,      0,            1,0);
    tbl[24] = v(0,0,0,      0,0,       0,1,32'hDEAD_BEEF,0,0,        0,0,      0,            1,0);
    tbl[25] = v(0,0,0,      0,0,       1,0,0,            1,B+'h540,  0,0,      0,            1,0);
    tbl[26] = v(0,0,0,      0,0,       0,1,32'hC000_0540,0,0,        0,0,      0,            1,0);
    tbl[27] = v(0,1,B+'h600,0,0,       1,0,0,            1,B+'h544,  1,B+'h540,32'hC000_0540,0,0);
    tbl[28] = v(0,1,B+'h700,0,0,       0,1,32'h0BAD_0BAD,0,0,        0,0,      0,            1,0);
    tbl[29] = v(0,0,0,      0,0,       1,0,0,            1,B+'h700,  0,0,      0,            1,0);
    tbl[30] = v(0,0,0,      0,0,       0,1,32'hC000_0700,0,0,        0,0,      0,            1,0);
    tbl[31] = v(0,0,0,      0,0,       0,0,0,            1,B+'h704,  1,B+'h700,32'hC000_0700,0,0);
    tbl[32] = v(0,0,0,      0,0,       0,0,0,            1,B+'h704,  0,0,      0,            1,0);

    rst_i = 1'b0;
    stall_i = 0; flush_i = 0; new_pc_i = '0; branch_flag_i = 0; branch_to_addr_i = '0;
    inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset("rst");
    rst_i = 1'b1;

    for (int i = 0; i < 33; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Reset with a request still on the bus
    rst_i = 1'b0;
    stall_i = 0; flush_i = 0; branch_flag_i = 0; inst_addr_ok_i = 0; inst_data_ok_i = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk_reset("mid_rst");
    rst_i = 1'b1;

    // Flush from IDLE, PC wrap, flush with no handshake started, branch to a misaligned target
    apply(v(0,1,32'hFFFF_FFF8,0,0, 0,0,0, 0,0,0,0,0,0,0), "h0");
    apply(v(0,0,0,0,0, 1,0,0, 1,32'hFFFF_FFF8,0,0,0,1,0), "h1");
    apply(v(0,0,0,0,0, 0,1,32'hE000_0000, 0,0,0,0,0,1,0), "h2");
    apply(v(1,0,0,0,0, 0,0,0, 0,0,1,32'hFFFF_FFF8,32'hE000_0000,0,0), "h3");
    apply(v(0,0,0,0,0, 1,0,0, 1,32'hFFFF_FFFC,1,32'hFFFF_FFF8,32'hE000_0000,0,0), "h4");
    apply(v(0,0,0,0,0, 0,1,32'hE000_0001, 0,0,0,0,0,1,0), "h5");
    apply(v(1,0,0,0,0, 0,0,0, 0,0,1,32'hFFFF_FFFC,32'hE000_0001,0,0), "h6");
    apply(v(0,0,0,0,0, 1,0,0, 1,32'h0000_0000,1,32'hFFFF_FFFC,32'hE000_0001,0,0), "h7_wrap");
    apply(v(0,0,0,0,0, 0,1,32'hE000_0002, 0,0,0,0,0,1,0), "h8");
    apply(v(1,1,32'h0000_0040,0,0, 0,0,0, 0,0,1,32'h0000_0000,32'hE000_0002,0,0), "h9");
    apply(v(0,0,0,1,B+'h102, 1,0,0, 1,32'h0000_0040,0,0,0,1,0), "h10");
    apply(v(0,0,0,0,0, 0,1,32'hE000_0003, 0,0,0,0,0,1,0), "h11");
`ifdef IF_ALIGN_CHECK_EN
    apply(v(0,0,0,0,0, 0,0,0, 0,0,1,32'h0000_0040,32'hE000_0003,0,0), "h12");
    apply(v(1,0,0,0,0, 0,0,0, 0,0,1,B+'h102,32'h0,0,1), "h13_adel");
    apply(v(0,0,0,0,0, 0,0,0, 0,0,1,B+'h102,32'h0,0,1), "h14_adel");
    apply(v(0,1,B+'h380,0,0, 0,0,0, 0,0,0,0,0,0,1), "h15");
    apply(v(0,0,0,0,0, 0,0,0, 1,B+'h380,0,0,0,1,0), "h16");
`else
    apply(v(0,0,0,0,0, 1,0,0, 1,B+'h102,1,32'h0000_0040,32'hE000_0003,0,0), "h12_misal");
    apply(v(0,0,0,0,0, 0,1,32'hE000_0004, 0,0,0,0,0,1,0), "h13");
    apply(v(0,0,0,0,0, 0,0,0, 1,B+'h106,1,B+'h102,32'hE000_0004,0,0), "h14");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
